// File: rtl/usb_rx_decoder.sv
// USB full-speed receive bit decoder: NRZI decode, SYNC detect, bit-unstuffing,
// byte assembly and EOP detection, advancing only on the bit timer's shift_enable.
module usb_rx_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int          STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    input  logic       shift_enable,
    output logic [7:0] rcv_data,
    output logic       byte_ready,
    output logic       rcving,
    output logic       eop,
    output logic       stuff_err,
    output logic       frame_err
);

    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        DATA     = 3'd2,
        EOP_WAIT = 3'd3,
        ERR      = 3'd4
    } state_t;

    state_t          state_q;
    logic            prev_line_q;   // 1 = J, 0 = K
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt_q;
    logic [OW-1:0]   ones_cnt_q;
    logic            err_flag_q;    // packet already reported a frame/stuff error

    logic            line_j, line_k, line_se0, line_se1;
    logic            nrzi_bit;
    logic            stuff_pending;
    logic [7:0]      shift_d;
    logic [2:0]      bit_cnt_d;
    logic [OW-1:0]   ones_cnt_d;

    assign line_j   =  d_plus_sync & ~d_minus_sync;
    assign line_k   = ~d_plus_sync &  d_minus_sync;
    assign line_se0 = ~d_plus_sync & ~d_minus_sync;
    assign line_se1 =  d_plus_sync &  d_minus_sync;

    // No transition decodes as 1; only meaningful on J/K samples.
    assign nrzi_bit      = (line_j == prev_line_q);
    assign stuff_pending = (ones_cnt_q == OW'(STUFF_LEN));
    assign shift_d       = {nrzi_bit, shift_q[7:1]};
    assign bit_cnt_d     = bit_cnt_q + 3'd1;
    assign ones_cnt_d    = nrzi_bit ? (ones_cnt_q + OW'(1)) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_line_q <= 1'b1;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            ones_cnt_q  <= '0;
            err_flag_q  <= 1'b0;
            rcv_data    <= 8'h00;
            byte_ready  <= 1'b0;
            rcving      <= 1'b0;
            eop         <= 1'b0;
            stuff_err   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            eop        <= 1'b0;
            stuff_err  <= 1'b0;
            frame_err  <= 1'b0;

            if (shift_enable) begin
                if (line_j || line_k) begin
                    prev_line_q <= line_j;
                end

                case (state_q)
                    IDLE: begin
                        if (line_k) begin
                            shift_q    <= {1'b0, shift_q[7:1]};
                            bit_cnt_q  <= 3'd1;
                            ones_cnt_q <= '0;
                            err_flag_q <= 1'b0;
                            rcving     <= 1'b1;
                            state_q    <= SYNC;
                        end
                    end

                    SYNC, DATA: begin
                        if (line_se0) begin
                            state_q <= EOP_WAIT;
                            if (state_q == SYNC || bit_cnt_q != 3'd0) begin
                                frame_err  <= 1'b1;
                                err_flag_q <= 1'b1;
                            end
                        end else if (line_se1) begin
                            frame_err  <= 1'b1;
                            err_flag_q <= 1'b1;
                            state_q    <= ERR;
                        end else if (stuff_pending) begin
                            // Stuffed bit: never shifted or counted, must be a transition.
                            ones_cnt_q <= '0;
                            if (nrzi_bit) begin
                                stuff_err  <= 1'b1;
                                err_flag_q <= 1'b1;
                                state_q    <= ERR;
                            end
                        end else begin
                            shift_q    <= shift_d;
                            bit_cnt_q  <= bit_cnt_d;
                            ones_cnt_q <= ones_cnt_d;
                            if (bit_cnt_d == 3'd0) begin
                                if (state_q == SYNC) begin
                                    if (shift_d == SYNC_BYTE) begin
                                        state_q <= DATA;
                                    end else begin
                                        frame_err  <= 1'b1;
                                        err_flag_q <= 1'b1;
                                        state_q    <= ERR;
                                    end
                                end else begin
                                    rcv_data   <= shift_d;
                                    byte_ready <= 1'b1;
                                end
                            end
                        end
                    end

                    EOP_WAIT: begin
                        if (line_j) begin
                            eop        <= ~err_flag_q;
                            err_flag_q <= 1'b0;
                            bit_cnt_q  <= 3'd0;
                            ones_cnt_q <= '0;
                            rcving     <= 1'b0;
                            state_q    <= IDLE;
                        end else if (!line_se0) begin
                            frame_err  <= 1'b1;
                            err_flag_q <= 1'b1;
                            state_q    <= ERR;
                        end
                    end

                    ERR: begin
                        if (line_se0) begin
                            state_q <= EOP_WAIT;
                        end
                    end

                    default: begin
                        rcving  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: stimulus pushes expected pulses into a queue,
// an independent monitor pops and compares each pulse the decoder produces.
module tb_usb_rx_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_plus_sync = 1'b1;
    logic       d_minus_sync = 1'b0;
    logic       shift_enable = 1'b0;
    logic [7:0] rcv_data;
    logic       byte_ready, rcving, eop, stuff_err, frame_err;

    usb_rx_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .shift_enable (shift_enable),
        .rcv_data     (rcv_data),
        .byte_ready   (byte_ready),
        .rcving       (rcving),
        .eop          (eop),
        .stuff_err    (stuff_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_BYTE, EV_EOP, EV_STUFF, EV_FRAME} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    logic enc_line;   // 1 = J
    int   enc_ones;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", name, actual);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: got kind %0d data 0x%0h, expected none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.data !== d)) begin
                miscompares++;
                $display("FAIL pulse: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                         k, d, e.kind, e.data);
            end else begin
                $display("ok   pulse kind %0d data 0x%0h", k, d);
            end
        end
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (byte_ready === 1'b1) mon_event(EV_BYTE, rcv_data);
        if (eop === 1'b1)        mon_event(EV_EOP, 8'h00);
        if (stuff_err === 1'b1)  mon_event(EV_STUFF, 8'h00);
        if (frame_err === 1'b1)  mon_event(EV_FRAME, 8'h00);
    end

    task automatic sample(input logic p, input logic m);
        @(negedge clk);
        d_plus_sync  = p;
        d_minus_sync = m;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_raw(input logic b);
        if (!b) enc_line = ~enc_line;
        sample(enc_line, ~enc_line);
    endtask

    task automatic send_bit(input logic b);
        send_raw(b);
        if (b) begin
            enc_ones++;
            if (enc_ones == 6) begin
                send_raw(1'b0);
                enc_ones = 0;
            end
        end else begin
            enc_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic start_pkt();
        enc_line = 1'b1;
        enc_ones = 0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic end_pkt();
        sample(1'b0, 1'b0);
        sample(1'b0, 1'b0);
        sample(1'b1, 1'b0);
        enc_line = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1;
        check("reset_rcv_data", rcv_data, 8'h00);
        check("reset_rcving", rcving, 0);
        check("reset_pulses", {byte_ready, eop, stuff_err, frame_err}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of the second byte of a packet.
        push(EV_BYTE, 8'h3C);
        start_pkt();
        send_sync();
        send_byte(8'h3C);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre_reset_rcv_data", rcv_data, 8'h3C);
        check("pre_reset_rcving", rcving, 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_rcv_data", rcv_data, 8'h00);
        check("async_reset_rcving", rcving, 0);
        check("async_reset_pulses", {byte_ready, eop, stuff_err, frame_err}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset_drained", exp_q.size(), 0);

        // Clean packet carrying 0xA5.
        push(EV_BYTE, 8'hA5);
        push(EV_EOP, 8'h00);
        start_pkt();
        send_sync();
        check("clean_rcving_high", rcving, 1);
        send_byte(8'hA5);
        end_pkt();
        check("clean_rcv_data", rcv_data, 8'hA5);
        check("clean_rcving_low", rcving, 0);
        check("clean_drained", exp_q.size(), 0);

        // 0xFF forces a stuffed 0 (one 1 carried in from SYNC), then 0x01.
        push(EV_BYTE, 8'hFF);
        push(EV_BYTE, 8'h01);
        push(EV_EOP, 8'h00);
        start_pkt();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        end_pkt();
        check("stuff_rcv_data", rcv_data, 8'h01);
        check("stuff_drained", exp_q.size(), 0);

        // Six decoded 1s followed by a non-transition.
        push(EV_STUFF, 8'h00);
        start_pkt();
        send_sync();
        for (int i = 0; i < 6; i++) send_raw(1'b1);
        end_pkt();
        check("stuffviol_rcving_low", rcving, 0);
        check("stuffviol_drained", exp_q.size(), 0);

        // Bad SYNC KJKJKJKJ, rest of packet ignored.
        push(EV_FRAME, 8'h00);
        start_pkt();
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_byte(8'hA5);
        end_pkt();
        check("badsync_drained", exp_q.size(), 0);

        // SE1 in IDLE is silently ignored.
        sample(1'b1, 1'b1);
        sample(1'b1, 1'b1);
        check("se1_idle_rcving", rcving, 0);

        // Partial byte at EOP.
        push(EV_FRAME, 8'h00);
        start_pkt();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        end_pkt();
        check("partial_rcv_data_held", rcv_data, 8'h01);
        check("partial_drained", exp_q.size(), 0);

        repeat (4) @(negedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
